vram_slot_sequencer: RTL and testbench

- Consumes the five one-hot phase strobes and the gated reset produced by the clock generator.
- Runs on the serial (x5) clock and time-multiplexes one external VRAM access per 5-cycle pixel slot among three requesters: display fetch, CPU port and command engine.
- Provides req/ack handshakes upstream and a single-port SRAM-style strobe interface downstream.

---
 rtl/vram_slot_sequencer.sv | 136 +++++++++++++
 tb/tb_vram_slot_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_sequencer.sv
// Time-multiplexes one VRAM access per 5-phase pixel slot among display fetch,
// CPU port and command engine; SRAM-style strobes downstream, req/ack upstream.
module vram_slot_sequencer #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 8,
   parameter int MAX_DISP_RUN = 4
) (
   input  logic              I_clock,
   input  logic              I_N_rst,
   input  logic [4:0]        I_phase,
   input  logic              I_disp_req,
   input  logic [ADDR_W-1:0] I_disp_addr,
   output logic              O_disp_ack,
   input  logic              I_cpu_req,
   input  logic              I_cpu_we,
   input  logic [ADDR_W-1:0] I_cpu_addr,
   input  logic [DATA_W-1:0] I_cpu_wdata,
   output logic              O_cpu_ack,
   input  logic              I_cmd_req,
   input  logic              I_cmd_we,
   input  logic [ADDR_W-1:0] I_cmd_addr,
   input  logic [DATA_W-1:0] I_cmd_wdata,
   output logic              O_cmd_ack,
   output logic [DATA_W-1:0] O_rdata,
   output logic              O_mem_ce,
   output logic              O_mem_we,
   output logic [ADDR_W-1:0] O_mem_addr,
   output logic [DATA_W-1:0] O_mem_wdata,
   input  logic [DATA_W-1:0] I_mem_rdata,
   output logic              O_phase_err
);
   localparam int CNT_W = $clog2(MAX_DISP_RUN + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_ACK} slot_t;
   typedef enum logic [1:0] {G_DISP, G_CPU, G_CMD} grant_t;

   slot_t            r_state;
   grant_t           r_grant;
   logic             r_we;
   logic             r_ptr_cmd;
   logic [CNT_W-1:0] r_run;
   logic [4:0]       r_prev_phase;

   logic       w_onehot, w_err, w_cc_any, w_both;
   logic       w_disp_win, w_cpu_win, w_cmd_win;
   logic [4:0] w_expect;

   // r_prev_phase == 0 means "no history": any one-hot pattern is accepted
   assign w_onehot   = (I_phase != 5'd0) && ((I_phase & (I_phase - 5'd1)) == 5'd0);
   assign w_expect   = {r_prev_phase[3:0], r_prev_phase[4]};
   assign w_err      = !w_onehot || ((r_prev_phase != 5'd0) && (I_phase != w_expect));
   assign w_cc_any   = I_cpu_req | I_cmd_req;
   assign w_both     = I_cpu_req & I_cmd_req;
   assign w_disp_win = I_disp_req && (r_run < CNT_W'(MAX_DISP_RUN));
   assign w_cpu_win  = !w_disp_win && I_cpu_req && (!I_cmd_req || !r_ptr_cmd);
   assign w_cmd_win  = !w_disp_win && I_cmd_req && !w_cpu_win;

   always_ff @(posedge I_clock) begin
      if (!I_N_rst) begin
         r_state      <= S_IDLE;
         r_grant      <= G_DISP;
         r_we         <= 1'b0;
         r_ptr_cmd    <= 1'b0;
         r_run        <= '0;
         r_prev_phase <= 5'd0;
         O_disp_ack   <= 1'b0;
         O_cpu_ack    <= 1'b0;
         O_cmd_ack    <= 1'b0;
         O_rdata      <= '0;
         O_mem_ce     <= 1'b0;
         O_mem_we     <= 1'b0;
         O_mem_addr   <= '0;
         O_mem_wdata  <= '0;
         O_phase_err  <= 1'b0;
      end else begin
         r_prev_phase <= w_err ? 5'd0 : I_phase;
         O_phase_err  <= w_err;
         O_disp_ack   <= 1'b0;
         O_cpu_ack    <= 1'b0;
         O_cmd_ack    <= 1'b0;
         if (w_err) begin
            r_state  <= S_IDLE;
            O_mem_ce <= 1'b0;
            O_mem_we <= 1'b0;
         end else if (I_phase[0]) begin
            r_run <= (w_disp_win && w_cc_any) ? r_run + 1'b1 : '0;
            // a lone requester leaves the pointer on itself; contention flips it
            if (!w_disp_win && w_cc_any)
               r_ptr_cmd <= w_both ? !r_ptr_cmd : w_cmd_win;
            if (w_disp_win) begin
               r_state    <= S_SETUP;
               r_grant    <= G_DISP;
               r_we       <= 1'b0;
               O_mem_ce   <= 1'b1;
               O_mem_we   <= 1'b0;
               O_mem_addr <= I_disp_addr;
            end else if (w_cpu_win) begin
               r_state     <= S_SETUP;
               r_grant     <= G_CPU;
               r_we        <= I_cpu_we;
               O_mem_ce    <= 1'b1;
               O_mem_we    <= I_cpu_we;
               O_mem_addr  <= I_cpu_addr;
               O_mem_wdata <= I_cpu_wdata;
            end else if (w_cmd_win) begin
               r_state     <= S_SETUP;
               r_grant     <= G_CMD;
               r_we        <= I_cmd_we;
               O_mem_ce    <= 1'b1;
               O_mem_we    <= I_cmd_we;
               O_mem_addr  <= I_cmd_addr;
               O_mem_wdata <= I_cmd_wdata;
            end else begin
               r_state <= S_IDLE;
            end
         end else begin
            case (r_state)
               S_SETUP:  r_state <= S_ACCESS;
               S_ACCESS: begin
                  r_state  <= S_CAPTURE;
                  O_mem_ce <= 1'b0;
                  O_mem_we <= 1'b0;
               end
               S_CAPTURE: begin
                  r_state    <= S_ACK;
                  O_disp_ack <= (r_grant == G_DISP);
                  O_cpu_ack  <= (r_grant == G_CPU);
                  O_cmd_ack  <= (r_grant == G_CMD);
                  if (!r_we) O_rdata <= I_mem_rdata;
               end
               default:  r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vram_slot_sequencer.sv
// Slot-level bench: a transaction model picks each slot's winner from the
// arbitration rules and predicts strobes, acks and read data per phase.
module tb_vram_slot_sequencer;
   localparam int AW = 17, DW = 8, MAXR = 4;

   logic          clk = 1'b0;
   logic          I_N_rst;
   logic [4:0]    I_phase;
   logic          I_disp_req, I_cpu_req, I_cpu_we, I_cmd_req, I_cmd_we;
   logic [AW-1:0] I_disp_addr, I_cpu_addr, I_cmd_addr;
   logic [DW-1:0] I_cpu_wdata, I_cmd_wdata, I_mem_rdata;
   logic          O_disp_ack, O_cpu_ack, O_cmd_ack, O_mem_ce, O_mem_we, O_phase_err;
   logic [DW-1:0] O_rdata, O_mem_wdata;
   logic [AW-1:0] O_mem_addr;

   always #5 clk = ~clk;

   vram_slot_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_DISP_RUN(MAXR)) dut (
      .I_clock(clk), .I_N_rst(I_N_rst), .I_phase(I_phase),
      .I_disp_req(I_disp_req), .I_disp_addr(I_disp_addr), .O_disp_ack(O_disp_ack),
      .I_cpu_req(I_cpu_req), .I_cpu_we(I_cpu_we), .I_cpu_addr(I_cpu_addr),
      .I_cpu_wdata(I_cpu_wdata), .O_cpu_ack(O_cpu_ack),
      .I_cmd_req(I_cmd_req), .I_cmd_we(I_cmd_we), .I_cmd_addr(I_cmd_addr),
      .I_cmd_wdata(I_cmd_wdata), .O_cmd_ack(O_cmd_ack),
      .O_rdata(O_rdata), .O_mem_ce(O_mem_ce), .O_mem_we(O_mem_we),
      .O_mem_addr(O_mem_addr), .O_mem_wdata(O_mem_wdata), .I_mem_rdata(I_mem_rdata),
      .O_phase_err(O_phase_err)
   );

   int n_cmp = 0, n_bad = 0;
   // model state: display run length, round-robin side (0=CPU,1=cmd), last read byte
   int        m_run;
   int        m_ptr;
   logic [7:0] m_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] strobes();
      return {O_phase_err, O_mem_ce, O_mem_we, O_disp_ack, O_cpu_ack, O_cmd_ack};
   endfunction

   function automatic logic [4:0] ph(input int k);
      return 5'(1 << k);
   endfunction

   task automatic step(input logic [4:0] p, input logic rstn);
      I_phase = p;
      I_N_rst = rstn;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_run = 0; m_ptr = 0; m_rdata = 8'h00;
   endtask

   task automatic do_reset();
      for (int k = 0; k < 5; k++) step(ph(k), 1'b0);
      model_reset();
   endtask

   // mode 0: normal slot, 1: phase pattern 0,1,1 then 2,3,4, 2: reset at phase 2
   // g returns the grant observed from the DUT's acks (0 none, 1 disp, 2 cpu, 3 cmd)
   task automatic run_slot(input int mode, input logic [7:0] rd, output int g);
      int win, side;
      logic ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic [2:0] ackv;
      bit cc;
      g = 0; ewe = 1'b0; ea = '0; ewd = '0;
      cc = I_cpu_req || I_cmd_req;
      if (I_disp_req && m_run < MAXR) begin
         win = 1;
         m_run = cc ? m_run + 1 : 0;
      end else begin
         m_run = 0;
         if (I_cpu_req && I_cmd_req) side = m_ptr;
         else if (I_cpu_req)         side = 0;
         else if (I_cmd_req)         side = 1;
         else                        side = -1;
         if (side < 0) win = 0;
         else begin
            win = 2 + side;
            if ((I_cpu_req && I_cmd_req) || side != m_ptr) m_ptr = 1 - m_ptr;
         end
      end
      case (win)
         1: ea = I_disp_addr;
         2: begin ea = I_cpu_addr; ewe = I_cpu_we; ewd = I_cpu_wdata; end
         3: begin ea = I_cmd_addr; ewe = I_cmd_we; ewd = I_cmd_wdata; end
         default: ;
      endcase
      ackv = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : (win == 3) ? 3'b001 : 3'b000;
      I_mem_rdata = rd;

      step(ph(0), 1'b1);
      chk("setup strobes", 32'(strobes()), 32'({1'b0, win != 0, ewe, 3'b000}));
      if (win != 0) chk("setup addr", 32'(O_mem_addr), 32'(ea));
      if (ewe) chk("setup wdata", 32'(O_mem_wdata), 32'(ewd));
      step(ph(1), 1'b1);
      chk("access strobes", 32'(strobes()), 32'({1'b0, win != 0, ewe, 3'b000}));
      if (mode == 1) begin
         step(ph(1), 1'b1);
         chk("phase err pulse", 32'(strobes()), 32'(6'b100000));
         for (int k = 2; k < 5; k++) begin
            step(ph(k), 1'b1);
            chk("aborted slot quiet", 32'(strobes()), 32'(6'b000000));
         end
         return;
      end
      if (mode == 2) begin
         step(ph(2), 1'b0);
         chk("reset strobes", 32'(strobes()), 32'(6'b000000));
         chk("reset rdata", 32'(O_rdata), 32'h0);
         model_reset();
         for (int k = 3; k < 5; k++) begin
            step(ph(k), 1'b1);
            chk("post-reset quiet", 32'(strobes()), 32'(6'b000000));
         end
         return;
      end
      step(ph(2), 1'b1);
      chk("capture strobes", 32'(strobes()), 32'(6'b000000));
      step(ph(3), 1'b1);
      if (win != 0 && !ewe) m_rdata = rd;
      chk("ack strobes", 32'(strobes()), 32'({3'b000, ackv}));
      chk("ack rdata", 32'(O_rdata), 32'(m_rdata));
      g = O_disp_ack ? 1 : O_cpu_ack ? 2 : O_cmd_ack ? 3 : 0;
      step(ph(4), 1'b1);
      chk("post-ack strobes", 32'(strobes()), 32'(6'b000000));
      chk("rdata held", 32'(O_rdata), 32'(m_rdata));
   endtask

   // requesters hold until acked; then or when idle they may start a fresh request
   task automatic stir(input int last);
      if (last == 1 || !I_disp_req) begin
         I_disp_req = ($urandom_range(0, 1) == 1); I_disp_addr = AW'($urandom);
      end
      if (last == 2 || !I_cpu_req) begin
         I_cpu_req = ($urandom_range(0, 2) == 0); I_cpu_we = $urandom_range(0, 1);
         I_cpu_addr = AW'($urandom); I_cpu_wdata = DW'($urandom);
      end
      if (last == 3 || !I_cmd_req) begin
         I_cmd_req = ($urandom_range(0, 2) == 0); I_cmd_we = $urandom_range(0, 1);
         I_cmd_addr = AW'($urandom); I_cmd_wdata = DW'($urandom);
      end
   endtask

   initial begin
      int g;
      I_disp_req = 0; I_cpu_req = 0; I_cmd_req = 0; I_cpu_we = 0; I_cmd_we = 0;
      I_disp_addr = '0; I_cpu_addr = '0; I_cmd_addr = '0;
      I_cpu_wdata = '0; I_cmd_wdata = '0; I_mem_rdata = '0;
      I_N_rst = 0; I_phase = 5'b00001;

      do_reset();
      chk("reset strobes", 32'(strobes()), 32'(6'b000000));
      chk("reset addr", 32'(O_mem_addr), 32'h0);
      chk("reset wdata", 32'(O_mem_wdata), 32'h0);
      chk("reset rdata", 32'(O_rdata), 32'h0);

      // CPU write alone
      I_cpu_req = 1; I_cpu_we = 1; I_cpu_addr = 17'h1ABCD; I_cpu_wdata = 8'h5A;
      run_slot(0, 8'h11, g);
      chk("cpu write grant", 32'(g), 32'd2);
      I_cpu_req = 0; I_cpu_we = 0;

      // display read alone
      I_disp_req = 1; I_disp_addr = 17'h00400;
      run_slot(0, 8'hC3, g);
      chk("disp read grant", 32'(g), 32'd1);
      chk("disp rdata", 32'(O_rdata), 32'hC3);
      I_disp_req = 0;

      // CPU and cmd contending alternate, starting with CPU
      do_reset();
      I_cpu_req = 1; I_cmd_req = 1; I_cmd_we = 1; I_cmd_wdata = 8'h77; I_cmd_addr = 17'h00010;
      for (int i = 0; i < 6; i++) begin
         run_slot(0, 8'($urandom), g);
         chk("rr order", 32'(g), (i % 2 == 0) ? 32'd2 : 32'd3);
      end
      I_cmd_req = 0; I_cmd_we = 0;

      // display vs CPU: four display grants then one CPU grant
      do_reset();
      I_disp_req = 1;
      for (int i = 0; i < 10; i++) begin
         run_slot(0, 8'($urandom), g);
         chk("disp run order", 32'(g), (i % 5 == 4) ? 32'd2 : 32'd1);
      end
      I_disp_req = 0;

      // illegal phase sequence aborts the slot, next slot grants normally
      I_cpu_we = 1; I_cpu_wdata = 8'h3C;
      run_slot(1, 8'h00, g);
      run_slot(0, 8'h00, g);
      chk("resume after phase err", 32'(g), 32'd2);

      // reset during the access phases of a CPU write
      run_slot(2, 8'h00, g);
      run_slot(0, 8'h00, g);
      chk("grant after mid reset", 32'(g), 32'd2);
      I_cpu_req = 0; I_cpu_we = 0;

      // randomized traffic
      g = 0;
      for (int i = 0; i < 400; i++) begin
         stir(g);
         run_slot(0, 8'($urandom), g);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
